hex_keypad_scanner: RTL and testbench

Scans a 4x4 hex keypad and reports each debounced key press as a 4-bit hex code with a one-cycle valid strobe. It is the input-side counterpart of the seven-segment display path: the display shows nibbles to the user, and this block takes nibbles from the user. It sits at the top level beside the display multiplexer. Its outputs feed register selection, the step button logic and the optional digit accumulator.

---
 rtl/hex_keypad_scanner_pkg.sv | 10 +
 rtl/keypad_sync2.sv | 12 +
 rtl/hex_keypad_scanner.sv | 110 +++++++++++
 tb/tb_hex_keypad_scanner.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/hex_keypad_scanner_pkg.sv
// hex_keypad_scanner_pkg: shared FSM states, key map and row reset constant for the keypad scanner
package hex_keypad_scanner_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;
  localparam logic [3:0] ROW_RST = 4'b1110;
  // nibble {row_idx, col_idx} holds the code printed on that key
  localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;
  function automatic logic [3:0] key_code(input logic [3:0] idx);
    return KEY_MAP[{idx, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/keypad_sync2.sv
// keypad_sync2: 4-bit two-flop synchroniser for the active-low column inputs
module keypad_sync2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] s1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {q, s1} <= '1;
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner: 4x4 keypad scan, debounce and hex strobe; KEYPAD_ENTRY_EN adds the 4-digit entry register
module hex_keypad_scanner
  import hex_keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  output logic [3:0]  key,
  output logic        key_valid,
  output logic        key_held
`ifdef KEYPAD_ENTRY_EN
  , output logic [15:0] entry
`endif
);
  localparam int TW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic ONE_SHOT = DEBOUNCE_CNT == 1;
  state_t state, state_n;
  logic [TW-1:0] tick;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [1:0] lc, lc_n, ci, ri;
  logic [3:0] col_s, row_n, row_nx, key_n;
  logic valid_n, held_n, sample, hit, done;
  keypad_sync2 u_sync (.clk(clk), .reset(reset), .d(col), .q(col_s));
  assign sample  = tick == TW'(SCAN_DIV - 1);
  assign hit     = ~&col_s;
  assign ci      = !col_s[0] ? 2'd0 : !col_s[1] ? 2'd1 : !col_s[2] ? 2'd2 : 2'd3;
  assign ri      = !row[0] ? 2'd0 : !row[1] ? 2'd1 : !row[2] ? 2'd2 : 2'd3;
  assign row_nx  = {row[2:0], row[3]};
  assign cnt_inc = cnt + 1'b1;
  assign done    = cnt_inc == CW'(DEBOUNCE_CNT);
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lc_n    = lc;
    row_n   = row;
    key_n   = key;
    valid_n = 1'b0;
    held_n  = key_held;
    if (sample)
      case (state)
        SCAN:
          if (!hit) row_n = row_nx;
          else begin
            lc_n    = ci;
            cnt_n   = CW'(1);
            state_n = ONE_SHOT ? PRESSED : DEBOUNCE;
            key_n   = ONE_SHOT ? key_code({ri, ci}) : key;
            valid_n = ONE_SHOT;
            held_n  = ONE_SHOT;
          end
        DEBOUNCE:
          if (hit && ci == lc) begin
            cnt_n   = cnt_inc;
            state_n = done ? PRESSED : DEBOUNCE;
            key_n   = done ? key_code({ri, ci}) : key;
            valid_n = done;
            held_n  = done;
          end else begin
            state_n = SCAN;
            row_n   = row_nx;
          end
        PRESSED:
          if (!hit) begin
            cnt_n   = CW'(1);
            state_n = ONE_SHOT ? SCAN : RELEASE;
            held_n  = !ONE_SHOT;
            row_n   = ONE_SHOT ? row_nx : row;
          end
        RELEASE:
          if (hit) state_n = PRESSED;
          else begin
            cnt_n   = cnt_inc;
            state_n = done ? SCAN : RELEASE;
            held_n  = !done;
            row_n   = done ? row_nx : row;
          end
        default: state_n = SCAN;
      endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= SCAN;
      tick      <= '0;
      cnt       <= '0;
      lc        <= '0;
      row       <= ROW_RST;
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      tick      <= sample ? '0 : tick + 1'b1;
      cnt       <= cnt_n;
      lc        <= lc_n;
      row       <= row_n;
      key       <= key_n;
      key_valid <= valid_n;
      key_held  <= held_n;
    end
`ifdef KEYPAD_ENTRY_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) entry <= '0;
    else if (key_valid) entry <= {entry[11:0], key};
`endif
endmodule

// File: tb/tb_hex_keypad_scanner.sv
// tb_hex_keypad_scanner: directed checks of scan, debounce, release, priority and reset with SCAN_DIV=4, DEBOUNCE_CNT=3
module tb_hex_keypad_scanner;
  logic clk = 1'b0, reset = 1'b0;
  logic [3:0] row, col, key;
  logic key_valid, key_held;
  logic [15:0] pressed = '0;
  int n_assert = 0, n_fail = 0, nstrobe = 0, cyc = 0, base = 0;
  logic [3:0] rows [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
`ifdef KEYPAD_ENTRY_EN
  logic [15:0] entry;
`endif
  hex_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .key(key),
    .key_valid(key_valid), .key_held(key_held)
`ifdef KEYPAD_ENTRY_EN
    , .entry(entry)
`endif
  );
  always #5 clk = ~clk;
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
  end
  always @(posedge clk or negedge reset) cyc <= !reset ? 0 : cyc + 1;
  always @(negedge clk) if (key_valid === 1'b1) nstrobe++;
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_valid(int lim);
    for (int i = 0; i < lim && key_valid !== 1'b1; i++) @(negedge clk);
    check("valid_seen", {15'd0, key_valid}, 16'd1);
  endtask
  task automatic wait_held_low(int lim);
    for (int i = 0; i < lim && key_held !== 1'b0; i++) @(negedge clk);
    check("held_low", {15'd0, key_held}, 16'd0);
  endtask
  task automatic wait_row(logic [3:0] r);
    for (int i = 0; i < 40 && row === r; i++) @(negedge clk);
    for (int i = 0; i < 40 && row !== r; i++) @(negedge clk);
    check("row_reached", {12'd0, row}, {12'd0, r});
  endtask
  task automatic press_release(int idx, logic [3:0] code, logic [15:0] ent);
    pressed[idx] = 1'b1;
    wait_valid(300);
    check("seq_key", {12'd0, key}, {12'd0, code});
    @(negedge clk);
`ifdef KEYPAD_ENTRY_EN
    check("entry", entry, ent);
`else
    if (ent == 16'hFFFF) $display("unused");
`endif
    pressed[idx] = 1'b0;
    wait_held_low(300);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_row", {12'd0, row}, 16'h000E);
    check("rst_key", {12'd0, key}, 16'h0);
    check("rst_valid", {15'd0, key_valid}, 16'd0);
    check("rst_held", {15'd0, key_held}, 16'd0);
    reset = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      check("idle_row", {12'd0, row}, {12'd0, rows[(n/4)%4]});
    end
    check("idle_strobes", 16'(nstrobe), 16'd0);
    // key 6 held steady, then timed release
    pressed[6] = 1'b1;
    wait_valid(200);
    check("k6_key", {12'd0, key}, 16'h6);
    check("k6_held", {15'd0, key_held}, 16'd1);
    repeat (40) @(negedge clk);
    check("k6_count", 16'(nstrobe), 16'd1);
    do @(negedge clk); while (cyc % 4 != 0);
    pressed[6] = 1'b0;
    repeat (11) @(negedge clk);
    check("k6_held_before", {15'd0, key_held}, 16'd1);
    @(negedge clk);
    check("k6_held_after", {15'd0, key_held}, 16'd0);
    // key D with a bounce: hit then miss sends the scan onward
    base = nstrobe;
    wait_row(4'b0111);
    pressed[15] = 1'b1;
    repeat (4) @(negedge clk);
    pressed[15] = 1'b0;
    repeat (4) @(negedge clk);
    check("kd_miss_row", {12'd0, row}, 16'h000E);
    check("kd_miss_count", 16'(nstrobe), 16'(base));
    wait_row(4'b0111);
    pressed[15] = 1'b1;
    repeat (11) @(negedge clk);
    check("kd_valid_early", {15'd0, key_valid}, 16'd0);
    @(negedge clk);
    check("kd_valid", {15'd0, key_valid}, 16'd1);
    check("kd_key", {12'd0, key}, 16'hD);
    check("kd_held", {15'd0, key_held}, 16'd1);
    @(negedge clk);
    check("kd_valid_pulse", {15'd0, key_valid}, 16'd0);
    check("kd_count", 16'(nstrobe), 16'(base + 1));
    pressed[15] = 1'b0;
    wait_held_low(100);
    // 2 and A together, then 1 added while pressed
    base = nstrobe;
    pressed[1] = 1'b1;
    pressed[3] = 1'b1;
    wait_valid(200);
    check("k2a_key", {12'd0, key}, 16'h2);
    pressed[0] = 1'b1;
    repeat (40) @(negedge clk);
    check("k2a_count", 16'(nstrobe), 16'(base + 1));
    check("k2a_key_kept", {12'd0, key}, 16'h2);
    pressed[3:0] = 4'h0;
    wait_held_low(100);
    // reset while debouncing key 6
    wait_row(4'b1101);
    pressed[6] = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_row", {12'd0, row}, 16'h000E);
    check("mid_rst_key", {12'd0, key}, 16'h0);
    check("mid_rst_valid", {15'd0, key_valid}, 16'd0);
    check("mid_rst_held", {15'd0, key_held}, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    base = nstrobe;
    wait_valid(200);
    check("post_rst_key", {12'd0, key}, 16'h6);
    repeat (40) @(negedge clk);
    check("post_rst_count", 16'(nstrobe), 16'(base + 1));
    pressed[6] = 1'b0;
    wait_held_low(100);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    press_release(0, 4'h1, 16'h0001);
    press_release(1, 4'h2, 16'h0012);
    press_release(2, 4'h3, 16'h0123);
    press_release(3, 4'hA, 16'h123A);
    press_release(5, 4'h5, 16'h23A5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
